// File: rtl/ctl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, datapath mux selects and the legality check.
package ctl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] PC_SRC_ALU = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC  = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   function automatic logic op_legal(
      input logic [6:0] op,
      input logic [2:0] f3,
      input logic       has_jal
   );
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         op == OP_R,
         op == OP_IMM:    ok = 1'b1;
         op == OP_LOAD,
         op == OP_STORE:  ok = (f3 == F3_W);
         op == OP_BRANCH: ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
         op == OP_JAL:    ok = has_jal;
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory port: request strobes out,
// single-cycle ready back from the memory.
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of the current memory request and flags
// a timeout once MEM_WAIT_MAX stalls have elapsed.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic stall,
   output logic timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_WAIT_MAX);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (stall && cnt != '1)
         cnt <= cnt + CNT_W'(1);
   end

   assign timeout = (MEM_WAIT_MAX > 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with
// memory stall tolerance, bus timeout and illegal-opcode trapping.
module multicycle_control
   import ctl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 4,
   parameter bit HAS_JAL      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   multicycle_control_if.master mem,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] state_o,
   output logic       illegal,
   output logic       bus_err
);

   state_t state, nxt;

   logic is_r, is_imm, is_load, is_store;
   logic is_br, is_jal, legal, taken;
   logic req, we, asel;
   logic timeout, clear, stall;
   logic unused_f7;

   // funct7_5 is decoded by the datapath ALU control, not here
   assign unused_f7 = funct7_5;

   assign is_r     = (opcode == OP_R);
   assign is_imm   = (opcode == OP_IMM);
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_br    = (opcode == OP_BRANCH);
   assign is_jal   = HAS_JAL && (opcode == OP_JAL);
   assign legal    = op_legal(opcode, funct3, HAS_JAL);
   assign taken    = ((funct3 == F3_BEQ) && zero)
                  || ((funct3 == F3_BNE) && !zero);

   assign stall = req && !mem.mem_ready;
   assign clear = (req && mem.mem_ready)
               || ((nxt == S_FETCH || nxt == S_MEM) && nxt != state);

   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .stall   (stall),
      .timeout (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_FETCH;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_FETCH: begin
            if (mem.mem_ready)
               nxt = S_DECODE;
            else if (timeout)
               nxt = S_HALT;
         end
         S_DECODE: nxt = legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            unique case (1'b1)
               is_r, is_imm:      nxt = S_WB;
               is_load, is_store: nxt = S_MEM;
               default:           nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem.mem_ready)
               nxt = is_store ? S_FETCH : S_WB;
            else if (timeout)
               nxt = S_HALT;
         end
         S_WB:    nxt = S_FETCH;
         default: nxt = S_HALT;
      endcase
   end

   always_comb begin
      req       = 1'b0;
      we        = 1'b0;
      asel      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_ALU;
      reg_write = 1'b0;
      wb_sel    = WB_SEL_ALU;
      alu_src_a = 1'b0;
      alu_src_b = SRC_B_RS2;
      alu_op    = ALU_OP_ADD;
      // reset must kill an in-flight request without waiting for a clock
      if (!rst) begin
         unique case (state)
            S_FETCH: begin
               req       = 1'b1;
               alu_src_b = SRC_B_FOUR;
               if (mem.mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_DECODE: alu_src_b = SRC_B_IMM;
            S_EXEC: begin
               unique case (1'b1)
                  is_r: begin
                     alu_src_a = 1'b1;
                     alu_op    = ALU_OP_FUNCT;
                  end
                  is_imm: begin
                     alu_src_a = 1'b1;
                     alu_src_b = SRC_B_IMM;
                     alu_op    = ALU_OP_FUNCT;
                  end
                  is_load, is_store: begin
                     alu_src_a = 1'b1;
                     alu_src_b = SRC_B_IMM;
                  end
                  is_br: begin
                     alu_src_a = 1'b1;
                     alu_op    = ALU_OP_SUB;
                     pc_src    = PC_SRC_BR;
                     pc_write  = taken;
                  end
                  is_jal: begin
                     pc_write  = 1'b1;
                     pc_src    = PC_SRC_JMP;
                     reg_write = 1'b1;
                     wb_sel    = WB_SEL_PC;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               req  = 1'b1;
               asel = 1'b1;
               we   = is_store;
            end
            S_WB: begin
               reg_write = 1'b1;
               wb_sel    = is_load ? WB_SEL_MEM : WB_SEL_ALU;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (state == S_DECODE && !legal)
            illegal <= 1'b1;
         if (stall && timeout)
            bus_err <= 1'b1;
      end
   end

   assign mem.mem_req      = req;
   assign mem.mem_we       = we;
   assign mem.mem_addr_sel = asel;
   assign state_o          = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: per-instruction plans of expected per-cycle
// strobes are queued by the driver and checked at negedge.
module tb_multicycle_control;

   localparam int MAXW = 3;
   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
   localparam int K_BR = 4, K_JAL = 5, K_ILL = 6;

   typedef struct packed {
      logic       rst;
      logic       rdy;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
   } stim_t;

   typedef struct packed {
      logic [2:0] st;
      logic       req, we, asel, irw, pcw;
      logic [1:0] pcs;
      logic       rw;
      logic [1:0] wbs;
      logic       sa;
      logic [1:0] sb;
      logic [1:0] aop;
      logic       ill, berr;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       rdy;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, zero;
   logic       ir_write, pc_write, reg_write;
   logic [1:0] pc_src, wb_sel, alu_src_b, alu_op;
   logic       alu_src_a, illegal, bus_err;
   logic [2:0] state_o;

   multicycle_control_if bus ();
   assign bus.mem_ready = rdy;

   multicycle_control #(
      .MEM_WAIT_MAX (MAXW),
      .CNT_W        (4),
      .HAS_JAL      (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .zero      (zero),
      .mem       (bus),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_src    (pc_src),
      .reg_write (reg_write),
      .wb_sel    (wb_sel),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .state_o   (state_o),
      .illegal   (illegal),
      .bus_err   (bus_err)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   stim_t stim_q[$];
   obs_t  exp_q[$];
   stim_t cur;
   bit    mf_ill, mf_berr;
   int    n_cmp = 0, n_bad = 0;
   int    force_f3 = -1, force_z = -1, force_ill = -1;

   always @(negedge clk) begin
      obs_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.st   = state_o;
         a.req  = bus.mem_req;
         a.we   = bus.mem_we;
         a.asel = bus.mem_addr_sel;
         a.irw  = ir_write;
         a.pcw  = pc_write;
         a.pcs  = pc_src;
         a.rw   = reg_write;
         a.wbs  = wb_sel;
         a.sa   = alu_src_a;
         a.sb   = alu_src_b;
         a.aop  = alu_op;
         a.ill  = illegal;
         a.berr = bus_err;
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL obs t=%0t got st=%0d vec=%h want st=%0d vec=%h",
                     $time, a.st, a, e.st, e);
         end
      end
   end

   function automatic obs_t idle(input int st);
      obs_t o;
      o      = '0;
      o.st   = 3'(st);
      o.ill  = mf_ill;
      o.berr = mf_berr;
      return o;
   endfunction

   task automatic emit(input logic r, input obs_t e);
      stim_t s;
      s     = cur;
      s.rst = 1'b0;
      s.rdy = r;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input int n);
      stim_t s;
      mf_ill  = 1'b0;
      mf_berr = 1'b0;
      repeat (n) begin
         s     = cur;
         s.rst = 1'b1;
         s.rdy = 1'($urandom_range(0, 1));
         stim_q.push_back(s);
         exp_q.push_back(idle(0));
      end
   endtask

   task automatic halt_hold(input int n);
      repeat (n) emit(1'($urandom_range(0, 1)), idle(5));
   endtask

   // status: 0 accepted, 1 timed out into HALT, 2 reset injected
   task automatic req_phase(input int st, input int stalls,
                            input int abort_at, input bit fetch,
                            input bit store, output int status);
      obs_t o;
      status = 0;
      for (int i = 0; i <= stalls; i++) begin
         o     = idle(st);
         o.req = 1'b1;
         if (fetch) o.sb = 2'd2;
         else begin
            o.asel = 1'b1;
            o.we   = store;
         end
         if (i == abort_at) begin
            status = 2;
            return;
         end
         if (i < stalls) begin
            emit(1'b0, o);
            if (i == MAXW) begin
               mf_berr = 1'b1;
               status  = 1;
               return;
            end
         end else begin
            if (fetch) begin
               o.irw = 1'b1;
               o.pcw = 1'b1;
            end
            emit(1'b1, o);
         end
      end
   endtask

   task automatic end_txn(input int status);
      if (status == 1) halt_hold($urandom_range(1, 3));
      do_reset($urandom_range(1, 2));
   endtask

   task automatic pick_illegal();
      int sel;
      sel = (force_ill >= 0) ? force_ill : $urandom_range(0, 6);
      case (sel)
         0: cur.op = 7'b1110011;
         1: begin cur.op = 7'b0000011; cur.f3 = 3'b000; end
         2: begin cur.op = 7'b0100011; cur.f3 = 3'b001; end
         3: begin cur.op = 7'b1100011; cur.f3 = 3'($urandom_range(2, 7)); end
         4: cur.op = 7'b1100111;
         5: cur.op = 7'b0110111;
         default: cur.op = 7'b0000000;
      endcase
   endtask

   task automatic run_instr(input int kind, input int fs, input int ms,
                            input int ab_f, input int ab_m);
      obs_t o;
      int   st;
      cur.f3 = 3'($urandom_range(0, 7));
      cur.f7 = 1'($urandom_range(0, 1));
      cur.z  = 1'($urandom_range(0, 1));
      case (kind)
         K_R:   cur.op = 7'b0110011;
         K_I:   cur.op = 7'b0010011;
         K_LW:  begin cur.op = 7'b0000011; cur.f3 = 3'b010; end
         K_SW:  begin cur.op = 7'b0100011; cur.f3 = 3'b010; end
         K_BR: begin
            cur.op = 7'b1100011;
            cur.f3 = (force_f3 >= 0) ? 3'(force_f3) : 3'($urandom_range(0, 1));
            if (force_z >= 0) cur.z = 1'(force_z);
         end
         K_JAL: cur.op = 7'b1101111;
         default: pick_illegal();
      endcase

      req_phase(0, fs, ab_f, 1'b1, 1'b0, st);
      if (st != 0) begin end_txn(st); return; end

      o    = idle(1);
      o.sb = 2'd1;
      emit(1'($urandom_range(0, 1)), o);
      if (kind == K_ILL) begin
         mf_ill = 1'b1;
         end_txn(1);
         return;
      end

      o = idle(2);
      case (kind)
         K_R:  begin o.sa = 1; o.aop = 2'd2; end
         K_I:  begin o.sa = 1; o.sb = 2'd1; o.aop = 2'd2; end
         K_LW, K_SW: begin o.sa = 1; o.sb = 2'd1; end
         K_BR: begin
            o.sa  = 1;
            o.aop = 2'd1;
            o.pcs = 2'd1;
            o.pcw = (cur.f3 == 3'd0) ? cur.z : !cur.z;
         end
         default: begin o.pcw = 1; o.pcs = 2'd2; o.rw = 1; o.wbs = 2'd2; end
      endcase
      emit(1'($urandom_range(0, 1)), o);
      if (kind == K_BR || kind == K_JAL) return;

      if (kind == K_LW || kind == K_SW) begin
         req_phase(3, ms, ab_m, 1'b0, kind == K_SW, st);
         if (st != 0) begin end_txn(st); return; end
         if (kind == K_SW) return;
      end

      o     = idle(4);
      o.rw  = 1'b1;
      o.wbs = (kind == K_LW) ? 2'd1 : 2'd0;
      emit(1'($urandom_range(0, 1)), o);
   endtask

   task automatic drive_all();
      stim_t s;
      while (stim_q.size() > 0) begin
         s        = stim_q.pop_front();
         rst      = s.rst;
         rdy      = s.rdy;
         opcode   = s.op;
         funct3   = s.f3;
         funct7_5 = s.f7;
         zero     = s.z;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int pick_stall();
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) return 0;
      if (r < 16) return $urandom_range(1, 2);
      if (r < 18) return MAXW;
      return MAXW + 1 + $urandom_range(0, 1);
   endfunction

   initial begin
      int fs, ms, af, am;
      rst = 1'b0; rdy = 1'b0; opcode = '0;
      funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
      cur = '0;
      #1;
      do_reset(2);                     drive_all();
      run_instr(K_R,   0, 0, -1, -1);  drive_all();
      run_instr(K_I,   0, 0, -1, -1);  drive_all();
      run_instr(K_LW,  0, 2, -1, -1);  drive_all();
      run_instr(K_SW,  0, 0, -1, -1);  drive_all();
      for (int f = 0; f < 2; f++)
         for (int z = 0; z < 2; z++) begin
            force_f3 = f;
            force_z  = z;
            run_instr(K_BR, 0, 0, -1, -1); drive_all();
         end
      force_f3 = -1;
      force_z  = -1;
      run_instr(K_JAL, 0, 0, -1, -1);  drive_all();
      force_ill = 0;
      run_instr(K_ILL, 0, 0, -1, -1);  drive_all();
      force_ill = 1;
      run_instr(K_ILL, 0, 0, -1, -1);  drive_all();
      force_ill = -1;
      run_instr(K_R, MAXW + 1, 0, -1, -1); drive_all();
      run_instr(K_R, MAXW, 0, -1, -1);     drive_all();
      run_instr(K_LW, 0, MAXW + 1, -1, -1); drive_all();
      run_instr(K_SW, 1, MAXW, -1, -1);    drive_all();
      run_instr(K_R, 3, 0, 2, -1);         drive_all();
      run_instr(K_LW, 0, 2, -1, 1);        drive_all();

      for (int n = 0; n < 300; n++) begin
         fs = pick_stall();
         ms = pick_stall();
         af = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2) : -1;
         am = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2) : -1;
         run_instr($urandom_range(0, 6), fs, ms, af, am);
         drive_all();
      end

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
